icache_fetch_responder: RTL

Direct-mapped instruction cache that answers the fetch stage's combinational PC lookups and replaces the flat instruction ROM. On a hit the instruction is returned in the same cycle. On a miss it asserts a stall, which the hazard unit uses to drop PCEn and IF_ID_En. It then refills the line from main memory through a request/grant plus beat-stream interface, and retries.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 59 +++++
 rtl/icache_fetch_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types, constants and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int words_per_line);
        return addr_w - $clog2(sets) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, synchronous word and tag writes, flash invalidate.
module icache_array
    import icache_pkg::*;
#(
    parameter int SETS           = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 25,
    localparam int IDX_W         = idx_w(SETS),
    localparam int OFF_W         = off_w(WORDS_PER_LINE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic             word_we_i,
    input  logic [31:0]      wr_data_i,
    input  logic             tag_we_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             set_valid_i,
    input  logic             inval_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][WORDS_PER_LINE];

    // Invalidate is applied before the line-complete set so a simultaneous flush is masked by the caller.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            if (inval_i) begin
                valid_q <= '0;
            end
            if (tag_we_i && set_valid_i) begin
                valid_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (word_we_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped I-cache front end: same-cycle hit lookup, stall on miss, line refill via req/gnt + beats.
module icache_fetch_responder
    import icache_pkg::*;
#(
    parameter int SETS           = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic [31:0]       instr_o,
    output logic              hit_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS_PER_LINE);
    localparam int LSB_W = OFF_W + 2;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

    state_e            state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] line_q;
    logic [OFF_W-1:0]  cnt_q;
    logic              drop_q;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             beat_we;
    logic             last_beat;
    logic             unused_byte_bits;

    assign off              = addr_i[OFF_W+1:2];
    assign idx              = addr_i[LSB_W +: IDX_W];
    assign tag              = addr_i[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^addr_i[1:0];

    assign hit_o     = req_i & rd_valid & (rd_tag == tag) & (state_q == IDLE);
    assign instr_o   = hit_o ? rd_data : NOP_INSTR;
    assign stall_o   = (req_i & ~hit_o) | (state_q != IDLE);
    assign beat_we   = (state_q == FILL) & mem_rvalid_i;
    assign last_beat = beat_we & (cnt_q == LAST_CNT);

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = line_q;

    icache_array #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (idx),
        .rd_off_i    (off),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_idx_i    (line_q[LSB_W +: IDX_W]),
        .wr_off_i    (cnt_q),
        .word_we_i   (beat_we),
        .wr_data_i   (mem_rdata_i),
        .tag_we_i    (last_beat),
        .wr_tag_i    (line_q[ADDR_W-1 -: TAG_W]),
        .set_valid_i (~drop_q & ~flush_i),
        .inval_i     (flush_i)
    );

    // A flush during a refill lets the beats drain but marks the line to be left invalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            line_q    <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && !hit_o && !flush_i) begin
                        line_q    <= {tag, idx, {LSB_W{1'b0}}};
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (beat_we) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    drop_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
